// File: rtl/execute_alu_pkg.sv
// execute_alu_pkg: shared ALUOP encodings, FSM states, iteration count and single-cycle op helper
package execute_alu_pkg;

    typedef enum logic [4:0] {
        ALUOP_ADD = 5'd0,
        ALUOP_SUB = 5'd1,
        ALUOP_AND = 5'd2,
        ALUOP_OR  = 5'd3,
        ALUOP_XOR = 5'd4,
        ALUOP_NOR = 5'd5,
        ALUOP_SLT = 5'd6,
        ALUOP_SLL = 5'd7,
        ALUOP_SRL = 5'd8,
        ALUOP_SRA = 5'd9,
        ALUOP_LUI = 5'd10,
        ALUOP_MOV = 5'd11,
        ALUOP_BEQ = 5'd12,
        ALUOP_BNE = 5'd13,
        ALUOP_MUL = 5'd14,
        ALUOP_DIV = 5'd15
    } aluop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int unsigned ITER_N    = 32;
    localparam logic [4:0]  ITER_LAST = 5'(ITER_N - 1);

    // Undefined codes, MUL and DIV fall to 0 here; the top routes MUL/DIV elsewhere.
    function automatic logic [31:0] single_op(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        case (op)
            ALUOP_ADD: return a + b;
            ALUOP_SUB: return a - b;
            ALUOP_AND: return a & b;
            ALUOP_OR:  return a | b;
            ALUOP_XOR: return a ^ b;
            ALUOP_NOR: return ~(a | b);
            ALUOP_SLT: return {31'd0, $signed(a) < $signed(b)};
            ALUOP_SLL: return b << sh;
            ALUOP_SRL: return b >> sh;
            ALUOP_SRA: return $unsigned($signed(b) >>> sh);
            ALUOP_LUI: return {b[15:0], 16'd0};
            ALUOP_MOV: return b;
            ALUOP_BEQ: return {31'd0, a == b};
            ALUOP_BNE: return {31'd0, a != b};
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: 32-iteration restoring signed divider, quotient truncates toward zero, remainder takes sign of dividend
module alu_divider
    import execute_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    logic        running_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        negq_q, negr_q;
    logic [32:0] shifted, diff;
    logic [31:0] rem_n, quo_n;

    // Magnitudes are divided unsigned; 0x80000000 stays representable as an unsigned magnitude.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
        quo_n   = {quo_q[30:0], ~diff[32]};
    end

    assign done_o      = running_q && cnt_q == ITER_LAST;
    assign quotient_o  = negq_q ? -quo_n : quo_n;
    assign remainder_o = negr_q ? -rem_n : rem_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else if (abort_i) begin
            running_q <= 1'b0;
        end else if (start_i) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= dividend_i[31] ? -dividend_i : dividend_i;
            dvs_q     <= divisor_i[31] ? -divisor_i : divisor_i;
            negq_q    <= dividend_i[31] ^ divisor_i[31];
            negr_q    <= dividend_i[31];
        end else if (running_q) begin
            rem_q     <= rem_n;
            quo_q     <= quo_n;
            cnt_q     <= cnt_q + 5'd1;
            running_q <= !done_o;
        end
    end

endmodule

// File: rtl/execute_alu.sv
// execute_alu: multi-cycle execute ALU (1-cycle ops, shift-add MUL, restoring DIV); ALU_FAST_MUL_EN selects a combinational multiplier
module execute_alu
    import execute_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [4:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic        zero
);

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d, hi_q, hi_d;
    logic [63:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [31:0] mplier_q, mplier_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod, sc_word, addend, mul_acc;
    logic        is_mul, is_div, div_done;
    logic [31:0] div_quo, div_rem;

`ifdef ALU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
    assign prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`else
    localparam bit FAST_MUL = 1'b0;
    assign prod = '0;
`endif

    assign is_mul  = aluop == ALUOP_MUL;
    assign is_div  = aluop == ALUOP_DIV && b != '0;
    assign sc_word = aluop == ALUOP_DIV ? {a, 32'hFFFF_FFFF}
                   : is_mul ? prod : {32'd0, single_op(aluop, a, b, shamt)};

    // Bit 31 of the multiplier carries negative weight, giving a signed product without sign fix-up.
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign mul_acc = cnt_q == ITER_LAST ? acc_q - addend : acc_q + addend;

    alu_divider u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (state_q == S_IDLE && start && !flush && is_div),
        .abort_i     (flush),
        .dividend_i  (a),
        .divisor_i   (b),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = is_div ? S_DIV : (is_mul && !FAST_MUL) ? S_MUL : S_DONE;
                if (state_d == S_DONE) {hi_d, result_d} = sc_word;
                mcand_d  = {{32{a[31]}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end
            S_MUL: begin
                acc_d    = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == ITER_LAST) begin
                    state_d          = S_DONE;
                    {hi_d, result_d} = mul_acc;
                end
            end
            S_DIV: if (div_done) begin
                state_d  = S_DONE;
                result_d = div_quo;
                hi_d     = div_rem;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            hi_d     = hi_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = state_q != S_IDLE;
    assign done   = state_q == S_DONE;
    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = result_q == '0;

endmodule

// File: tb/tb_execute_alu.sv
// tb_execute_alu: table vectors, directed corner sequences and random ops checked against an arithmetic reference model
module tb_execute_alu;
    import execute_alu_pkg::*;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [4:0]  aluop = '0, shamt = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, zero;
    logic [31:0] result, hi;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] r, h;
        int          lat;
        bit          hk;
    } vec_t;
    vec_t vq[$];

    execute_alu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .aluop(aluop),
        .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .hi(hi), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic [4:0] sh, input logic [31:0] r, input logic [31:0] h,
                           input int lat, input bit hk);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.sh = sh; v.r = r; v.h = h; v.lat = lat; v.hk = hk;
        vq.push_back(v);
    endtask

    function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh, output logic [31:0] r, output logic [31:0] h,
                                  output int lat, output bit hk);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint p;
        r = '0; h = '0; lat = 1; hk = 1'b0;
        case (op)
            ALUOP_ADD: r = x + y;
            ALUOP_SUB: r = x - y;
            ALUOP_AND: r = x & y;
            ALUOP_OR:  r = x | y;
            ALUOP_XOR: r = x ^ y;
            ALUOP_NOR: r = ~(x | y);
            ALUOP_SLT: r = (sx < sy) ? 32'd1 : 32'd0;
            ALUOP_SLL: r = y << sh;
            ALUOP_SRL: r = y >> sh;
            ALUOP_SRA: begin p = sy >>> sh; r = p[31:0]; end
            ALUOP_LUI: r = y * 32'd65536;
            ALUOP_MOV: r = y;
            ALUOP_BEQ: r = (x == y) ? 32'd1 : 32'd0;
            ALUOP_BNE: r = (x != y) ? 32'd1 : 32'd0;
            ALUOP_MUL: begin p = sx * sy; r = p[31:0]; h = p[63:32]; lat = MUL_LAT; hk = 1'b1; end
            ALUOP_DIV: begin
                hk = 1'b1;
                if (y == 0) begin r = 32'hFFFF_FFFF; h = x; end
                else begin p = sx / sy; r = p[31:0]; p = sx % sy; h = p[31:0]; lat = 33; end
            end
            default: hk = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [4:0] sh, input logic [31:0] er,
                          input logic [31:0] eh, input int el, input bit hk);
        int lat;
        @(negedge clk);
        aluop = op; a = ia; b = ib; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom); aluop = 5'($urandom);
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, ".lat"}, lat, el);
        chk({nm, ".busy"}, busy, 1'b1);
        chk({nm, ".result"}, result, er);
        chk({nm, ".zero"}, zero, er == 0);
        if (hk) chk({nm, ".hi"}, hi, eh);
        @(posedge clk); #1;
        chk({nm, ".idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [31:0] er, eh, ra, rb;
        logic [4:0]  rop, rsh;
        int          el, n;
        bit          hk;

        add_vec(ALUOP_ADD, 32'd7, 32'hFFFF_FFFD, 5'd0, 32'd4, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SUB, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SRA, 32'd0, 32'h7FFF_FFFF, 5'd4, 32'h07FF_FFFF, 32'd0, 1, 1'b0);
        add_vec(ALUOP_LUI, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 32'd0, 1, 1'b0);
        add_vec(ALUOP_MUL, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
        add_vec(ALUOP_MUL, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'd0, 32'h4000_0000, MUL_LAT, 1'b1);
        add_vec(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b1);
        add_vec(ALUOP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0, 32'hFFFF_FFFD, 32'd1, 33, 1'b1);
        add_vec(ALUOP_DIV, 32'h1234_5678, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1'b1);
        add_vec(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 32'd0, 33, 1'b1);
        add_vec(ALUOP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0, 1, 1'b0);
        add_vec(ALUOP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 32'd0, 1, 1'b0);
        add_vec(ALUOP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 32'd0, 1, 1'b0);
        add_vec(ALUOP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 32'd0, 1, 1'b0);
        add_vec(ALUOP_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SLL, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 32'd0, 1, 1'b0);
        add_vec(ALUOP_SRL, 32'd0, 32'h8000_0000, 5'd31, 32'd1, 32'd0, 1, 1'b0);
        add_vec(ALUOP_MOV, 32'd0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 32'd0, 1, 1'b0);
        add_vec(ALUOP_BEQ, 32'd5, 32'd5, 5'd0, 32'd1, 32'd0, 1, 1'b0);
        add_vec(ALUOP_BNE, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, 1, 1'b0);
        add_vec(ALUOP_BNE, 32'd5, 32'd6, 5'd0, 32'd1, 32'd0, 1, 1'b0);
        add_vec(5'd20, 32'd1, 32'd2, 5'd0, 32'd0, 32'd0, 1, 1'b1);

        #12;
        chk("reset.outputs", {busy, done, zero, result, hi}, {3'b001, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i])
            run_op($sformatf("vec%0d", i), vq[i].op, vq[i].a, vq[i].b, vq[i].sh,
                   vq[i].r, vq[i].h, vq[i].lat, vq[i].hk);

        // second start while busy is ignored
        @(negedge clk);
        aluop = ALUOP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        aluop = ALUOP_ADD; a = 32'd1; b = 32'd1;
        n = 0;
        for (int c = 0; c < 45; c++) begin
            if (c == 20) start = 1'b0;
            if (done) begin
                n++;
                chk("busystart.result", result, 32'd14);
                chk("busystart.hi", hi, 32'd2);
            end
            @(posedge clk); #1;
        end
        chk("busystart.pulses", n, 1);

        // flush at DIV cycle 10
        @(negedge clk);
        aluop = ALUOP_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flushdiv.next", {busy, done}, 2'b00);
        n = 0;
        repeat (40) begin @(posedge clk); #1; if (done) n++; end
        chk("flushdiv.nodone", n, 0);
        chk("flushdiv.held", result, 32'd14);

        // flush with simultaneous start drops the start
        @(negedge clk);
        aluop = ALUOP_ADD; a = 32'd1; b = 32'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flushstart.dropped", {busy, done}, 2'b00);

        // flush in DONE still shows done that cycle
        @(negedge clk);
        aluop = ALUOP_ADD; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        chk("flushdone.done", {done, result}, {1'b1, 32'd5});
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flushdone.after", {busy, done, result}, {2'b00, 32'd5});

        // reset mid-MUL
        @(negedge clk);
        aluop = ALUOP_MUL; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("resetmul.outputs", {busy, done, zero, result, hi}, {3'b001, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin @(posedge clk); #1; if (done) n++; end
        chk("resetmul.nodone", n, 0);

        // start accepted on first edge after reset release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; aluop = ALUOP_ADD; a = 32'd9; b = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("resetstart.done", {done, result}, {1'b1, 32'd10});
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            rop = 5'($urandom_range(0, 17));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            rsh = 5'($urandom);
            model(rop, ra, rb, rsh, er, eh, el, hk);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rsh, er, eh, el, hk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
